// File: rtl/video_dram_pkg.sv
// rtl/video_dram_pkg.sv - shared types and slot constants for the video DRAM scheduler
package video_dram_pkg;

  localparam int AW_DEF = 21;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_VIDEO   = 2'd1,
    OWN_CPU     = 2'd2,
    OWN_REFRESH = 2'd3
  } owner_e;

  // One bit per slot of the 8-cycle frame; a set bit marks a video slot.
  localparam logic [7:0] SLOT_MASK_BW8 = 8'b1000_0000;
  localparam logic [7:0] SLOT_MASK_BW4 = 8'b1000_1000;

  function automatic logic is_video_slot(input logic bw, input logic [2:0] slot);
    logic [7:0] mask;
    mask = bw ? SLOT_MASK_BW4 : SLOT_MASK_BW8;
    return mask[slot];
  endfunction

endpackage

// File: rtl/video_dram_sched_if.sv
// rtl/video_dram_sched_if.sv - video, CPU and DRAM controller signals of the scheduler
interface video_dram_sched_if #(
  parameter int AW = 21
);
  logic          cend;
  logic          pre_cend;
  logic          fetch_start;
  logic          video_go;
  logic          video_bw;
  logic          frame_start;
  logic [AW-1:0] video_base;
  logic          video_strobe;
  logic [15:0]   video_data;
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wrdata;
  logic [1:0]    cpu_bsel;
  logic          cpu_strobe;
  logic          dram_req;
  logic          dram_rnw;
  logic [AW-1:0] dram_addr;
  logic [15:0]   dram_wrdata;
  logic [1:0]    dram_bsel;
  logic          dram_refresh;
  logic [15:0]   dram_rddata;

  modport slave (
    input  cend, pre_cend, fetch_start, video_go, video_bw, frame_start, video_base,
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_bsel, dram_rddata,
    output video_strobe, video_data, cpu_strobe,
    output dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel, dram_refresh
  );

  modport master (
    output cend, pre_cend, fetch_start, video_go, video_bw, frame_start, video_base,
    output cpu_req, cpu_rnw, cpu_addr, cpu_wrdata, cpu_bsel, dram_rddata,
    input  video_strobe, video_data, cpu_strobe,
    input  dram_req, dram_rnw, dram_addr, dram_wrdata, dram_bsel, dram_refresh
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// rtl/dram_refresh_timer.sv - refresh interval timer with saturating pending-refresh count
module dram_refresh_timer #(
  parameter int REF_PERIOD  = 27,
  parameter int REF_MAXPEND = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cend,
  input  logic grant,
  output logic ref_pend_nz,
  output logic ref_urgent
);
  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int PW = $clog2(REF_MAXPEND + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          wrap;

  always_comb begin
    timer_d = timer_q;
    wrap    = 1'b0;
    if (cend) begin
      if (timer_q == TW'(REF_PERIOD - 1)) begin
        timer_d = '0;
        wrap    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    // A wrap landing on the same clock as a grant cancels out.
    pend_d = pend_q;
    if (wrap && !grant) begin
      if (pend_q != PW'(REF_MAXPEND)) pend_d = pend_q + 1'b1;
    end else if (grant && !wrap && pend_q != '0) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      pend_q  <= '0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
    end
  end

  assign ref_pend_nz = (pend_q != '0);
  assign ref_urgent  = (pend_q == PW'(REF_MAXPEND));

endmodule

// File: rtl/video_dram_sched.sv
// rtl/video_dram_sched.sv - per-DRAM-cycle owner selection between video, CPU and refresh
module video_dram_sched
  import video_dram_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int REF_PERIOD  = 27,
  parameter int REF_MAXPEND = 3
) (
  input logic               clk,
  input logic               rst,
  video_dram_sched_if.slave bus
);
  owner_e        owner_q, owner_d;
  logic [2:0]    slot_q, slot_d, nxt_slot;
  logic [AW-1:0] vaddr_q, vaddr_d;
  logic          req_q, req_d, rnw_q, rnw_d, rfsh_q, rfsh_d;
  logic          vstb_q, vstb_d, cstb_q, cstb_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    bsel_q, bsel_d;
  logic          vid_slot, ref_grant, ref_pend_nz, ref_urgent;

  dram_refresh_timer #(
    .REF_PERIOD (REF_PERIOD),
    .REF_MAXPEND(REF_MAXPEND)
  ) u_refresh (
    .clk        (clk),
    .rst        (rst),
    .cend       (bus.cend),
    .grant      (ref_grant),
    .ref_pend_nz(ref_pend_nz),
    .ref_urgent (ref_urgent)
  );

  always_comb begin
    nxt_slot = bus.fetch_start ? 3'd0 : slot_q + 3'd1;
    slot_d   = bus.cend ? nxt_slot : slot_q;
    vid_slot = bus.video_go && is_video_slot(bus.video_bw, nxt_slot);
  end

  // Next owner; a CPU cycle may never follow another CPU cycle directly.
  always_comb begin
    owner_d = owner_q;
    if (bus.pre_cend) begin
      if (vid_slot)                               owner_d = OWN_VIDEO;
      else if (ref_urgent)                        owner_d = OWN_REFRESH;
      else if (bus.cpu_req && owner_q != OWN_CPU) owner_d = OWN_CPU;
      else if (ref_pend_nz)                       owner_d = OWN_REFRESH;
      else                                        owner_d = OWN_NONE;
    end
  end

  always_comb begin
    req_d     = req_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bsel_d    = bsel_q;
    rfsh_d    = rfsh_q;
    vstb_d    = 1'b0;
    cstb_d    = 1'b0;
    ref_grant = bus.pre_cend && (owner_d == OWN_REFRESH);
    vaddr_d   = vaddr_q;
    if (bus.pre_cend) begin
      vstb_d = (owner_q == OWN_VIDEO);
      cstb_d = (owner_q == OWN_CPU);
      req_d  = (owner_d == OWN_VIDEO) || (owner_d == OWN_CPU);
      rfsh_d = (owner_d == OWN_REFRESH);
      case (owner_d)
        OWN_VIDEO: begin
          rnw_d   = 1'b1;
          addr_d  = vaddr_q;
          vaddr_d = vaddr_q + 1'b1;
        end
        OWN_CPU: begin
          rnw_d   = bus.cpu_rnw;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wrdata;
          bsel_d  = bus.cpu_bsel;
        end
        default: ;
      endcase
    end
    // A frame restart overrides the post-grant increment.
    if (bus.frame_start) vaddr_d = bus.video_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      slot_q  <= '0;
      vaddr_q <= '0;
      req_q   <= 1'b0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bsel_q  <= '0;
      rfsh_q  <= 1'b0;
      vstb_q  <= 1'b0;
      cstb_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      slot_q  <= slot_d;
      vaddr_q <= vaddr_d;
      req_q   <= req_d;
      rnw_q   <= rnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bsel_q  <= bsel_d;
      rfsh_q  <= rfsh_d;
      vstb_q  <= vstb_d;
      cstb_q  <= cstb_d;
    end
  end

  assign bus.video_strobe = vstb_q;
  assign bus.video_data   = bus.dram_rddata;
  assign bus.cpu_strobe   = cstb_q;
  assign bus.dram_req     = req_q;
  assign bus.dram_rnw     = rnw_q;
  assign bus.dram_addr    = addr_q;
  assign bus.dram_wrdata  = wdata_q;
  assign bus.dram_bsel    = bsel_q;
  assign bus.dram_refresh = rfsh_q;

endmodule

// File: tb/tb_video_dram_sched.sv
// tb/tb_video_dram_sched.sv - scoreboard bench for video_dram_sched
module tb_video_dram_sched;
  import video_dram_pkg::*;

  localparam int AW = 21;
  localparam owner_e N = OWN_NONE;
  localparam owner_e V = OWN_VIDEO;
  localparam owner_e C = OWN_CPU;
  localparam owner_e R = OWN_REFRESH;
  localparam logic [15:0] RD_PAT = 16'h5A3C;

  typedef struct {
    bit            req, rfsh, rnw, vs, cs;
    logic [AW-1:0] addr;
    logic [15:0]   wd;
    logic [1:0]    bs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  string tag = "reset";
  exp_t expq[$];

  bit            c_rnw;
  logic [AW-1:0] c_addr;
  logic [15:0]   c_wd;
  logic [1:0]    c_bs;

  video_dram_sched_if #(.AW(AW)) bus ();

  video_dram_sched #(.AW(AW), .REF_PERIOD(4), .REF_MAXPEND(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : monitor
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      if (bus.cend) begin
        cyc++;
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL %s cyc%0d: cend with no expected entry (req=%b ref=%b)", tag, cyc,
                   bus.dram_req, bus.dram_refresh);
        end else begin
          e  = expq.pop_front();
          ok = (bus.dram_req == e.req) && (bus.dram_refresh == e.rfsh) &&
               (bus.video_strobe == e.vs) && (bus.cpu_strobe == e.cs);
          if (e.req)
            ok = ok && (bus.dram_rnw == e.rnw) && (bus.dram_addr == e.addr) &&
                 (e.rnw || (bus.dram_wrdata == e.wd && bus.dram_bsel == e.bs));
          if (!ok) begin
            bad++;
            $display("FAIL %s cyc%0d: got req=%b ref=%b rnw=%b addr=%h wd=%h bs=%b vstb=%b cstb=%b, want req=%b ref=%b rnw=%b addr=%h wd=%h bs=%b vstb=%b cstb=%b",
                     tag, cyc, bus.dram_req, bus.dram_refresh, bus.dram_rnw, bus.dram_addr,
                     bus.dram_wrdata, bus.dram_bsel, bus.video_strobe, bus.cpu_strobe,
                     e.req, e.rfsh, e.rnw, e.addr, e.wd, e.bs, e.vs, e.cs);
          end
        end
        if (bus.video_strobe) begin
          total++;
          if (bus.video_data !== RD_PAT) begin
            bad++;
            $display("FAIL %s video_data: got %h want %h", tag, bus.video_data, RD_PAT);
          end
        end
      end
    end
  end

  task automatic chk_zero(input string nm);
    logic [AW+22:0] v;
    v = {bus.dram_req, bus.dram_rnw, bus.dram_refresh, bus.dram_addr, bus.dram_wrdata,
         bus.dram_bsel, bus.video_strobe, bus.cpu_strobe};
    total++;
    if (v !== '0) begin
      bad++;
      $display("FAIL %s: outputs=%h want 0", nm, v);
    end
  endtask

  task automatic do_reset(input string nm);
    tag = nm;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    chk_zero({nm, "_reset"});
  endtask

  task automatic set_cpu(input bit req, input bit rnw, input int addr, input int wd, input int bs);
    c_rnw  = rnw;
    c_addr = AW'(addr);
    c_wd   = 16'(wd);
    c_bs   = 2'(bs);
    bus.cpu_req    = req;
    bus.cpu_rnw    = c_rnw;
    bus.cpu_addr   = c_addr;
    bus.cpu_wrdata = c_wd;
    bus.cpu_bsel   = c_bs;
  endtask

  task automatic load_base(input int base);
    bus.video_base = AW'(base);
    @(posedge clk); #1 bus.frame_start = 1'b1;
    @(posedge clk); #1 bus.frame_start = 1'b0;
  endtask

  // One DRAM cycle: pre_cend clock, cend clock, two idle clocks.
  task automatic step(input owner_e o, input int a = 0, input int vs = 0, input int cs = 0,
                      input int fs = 0, input int fr = 0, input int rs = 0);
    exp_t e;
    e.req  = (o == OWN_VIDEO) || (o == OWN_CPU);
    e.rfsh = (o == OWN_REFRESH);
    e.vs   = (vs != 0);
    e.cs   = (cs != 0);
    if (o == OWN_VIDEO) begin
      e.rnw = 1'b1; e.addr = AW'(a); e.wd = '0; e.bs = '0;
    end else begin
      e.rnw = c_rnw; e.addr = c_addr; e.wd = c_wd; e.bs = c_bs;
    end
    expq.push_back(e);
    @(posedge clk); #1;
    bus.pre_cend = 1'b1; bus.fetch_start = (fs != 0); bus.frame_start = (fr != 0);
    @(posedge clk); #1;
    bus.pre_cend = 1'b0; bus.frame_start = 1'b0; bus.cend = 1'b1;
    if (rs != 0) rst = 1'b1;
    @(posedge clk); #1;
    bus.cend = 1'b0; bus.fetch_start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic cend_only();
    exp_t e;
    e = '{req: 0, rfsh: 0, rnw: 0, vs: 0, cs: 0, addr: '0, wd: '0, bs: '0};
    expq.push_back(e);
    @(posedge clk); #1 bus.cend = 1'b1;
    @(posedge clk); #1 bus.cend = 1'b0;
  endtask

  initial begin : stim
    bus.cend = 0; bus.pre_cend = 0; bus.fetch_start = 0; bus.video_go = 0; bus.video_bw = 0;
    bus.frame_start = 0; bus.video_base = '0; bus.dram_rddata = RD_PAT;
    set_cpu(0, 1, 0, 0, 0);

    // 1/8 bandwidth video alone; refresh fills free slots
    do_reset("bw8");
    bus.video_bw = 0; bus.video_go = 1;
    load_base('h40);
    step(N, 0, 0, 0, 1);
    step(N); step(N); step(N);
    step(R); step(N); step(N);
    step(V, 'h40);
    step(R, 0, 1, 0);
    step(N); step(N); step(N);
    step(R); step(N); step(N);
    step(V, 'h41);
    step(R, 0, 1, 0);

    // 1/4 bandwidth video with a held CPU write request
    do_reset("bw4_cpu");
    bus.video_bw = 1; bus.video_go = 1;
    set_cpu(1, 0, 'h1234, 'hBEEF, 2);
    load_base('h80);
    step(C, 0, 0, 0, 1);
    step(N, 0, 0, 1);
    step(C);
    step(V, 'h80, 0, 1);
    step(C, 0, 1, 0);
    step(R, 0, 0, 1);
    step(C);
    step(V, 'h81, 0, 1);
    step(C, 0, 1, 0);
    step(R, 0, 0, 1);
    step(C);
    step(V, 'h82, 0, 1);
    step(C, 0, 1, 0);
    step(R, 0, 0, 1);

    // refresh backlog saturates at 3 and then outranks the CPU
    do_reset("ref_urgent");
    bus.video_go = 0; bus.video_bw = 0;
    set_cpu(1, 1, 'h55, 0, 0);
    for (int k = 0; k < 16; k++) cend_only();
    step(R);
    step(C);
    step(R, 0, 0, 1);
    step(C);
    step(R, 0, 0, 1);
    step(C);
    step(R, 0, 0, 1);

    // frame_start on the same edge as a video grant
    do_reset("frame_load");
    bus.video_bw = 1; bus.video_go = 1;
    set_cpu(0, 1, 0, 0, 0);
    load_base('h1F);
    bus.video_base = AW'('h100);
    step(N, 0, 0, 0, 1);
    step(N); step(N);
    step(V, 'h1F, 0, 0, 0, 1);
    step(R, 0, 1, 0);
    step(N); step(N);
    step(V, 'h100);
    step(R, 0, 1, 0);

    // idle video slot handed to the CPU
    do_reset("free_slot");
    bus.video_bw = 0; bus.video_go = 0;
    set_cpu(0, 1, 'h777, 0, 0);
    step(N, 0, 0, 0, 1);
    set_cpu(1, 1, 'h777, 0, 0);
    step(C);
    step(N, 0, 0, 1);
    step(C);
    step(R, 0, 0, 1);
    step(C);
    step(N, 0, 0, 1);
    step(C);
    step(R, 0, 0, 1);

    // reset lands one clock after a CPU grant
    do_reset("rst_mid");
    bus.video_bw = 0; bus.video_go = 0;
    set_cpu(0, 0, 'h2AA, 'h1234, 1);
    step(N); step(N); step(N);
    set_cpu(1, 0, 'h2AA, 'h1234, 1);
    step(C, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    set_cpu(0, 0, 'h2AA, 'h1234, 1);
    bus.video_go = 1;
    @(posedge clk); #1;
    chk_zero("rst_mid_release");
    tag = "rst_mid_after";
    step(N); step(N); step(N); step(N);
    step(R); step(N);
    step(V, 0);
    step(N, 0, 1, 0);

    repeat (4) @(posedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL leftover_expected: got %0d pending entries want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
